// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz VGA timing constants and the coordinate type shared by
// the sync generator, its pixel interface and the blocks that consume it.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int HSYNC_START = H_DISPLAY + H_FRONT;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;
    localparam int VSYNC_START = V_DISPLAY + V_FRONT;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;

    localparam logic SYNC_ACTIVE = 1'b0;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic in_window(coord_t v, int lo, int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-coordinate and sync bundle: the generator is the master, game and
// renderer blocks (and the board pins) are slaves.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   p_tick;
    coord_t x;
    coord_t y;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   frame_tick;

    modport master (output p_tick, x, y, video_on, hsync, vsync, frame_tick);
    modport slave  (input  p_tick, x, y, video_on, hsync, vsync, frame_tick);

endinterface

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to a one-clk pixel enable every CLK_DIV clocks.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign p_tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel enable, x/y counters, registered video_on/hsync/vsync
// and a once-per-frame tick, all changing on the same clock edge.
module vga_sync_gen
    import vga_timing_pkg::coord_t;
    import vga_timing_pkg::SYNC_ACTIVE;
    import vga_timing_pkg::in_window;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    logic   p_tick;
    coord_t h_cnt, v_cnt;
    coord_t h_next, v_next;
    logic   h_wrap, v_wrap;
    logic   video_on_q, hsync_q, vsync_q, frame_tick_q;

    pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    // NOTE: every always_comb output gets a default first, so no path leaves
    // one unassigned and infers a latch.
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        h_next = h_wrap ? '0 : h_cnt + 1'b1;
        v_next = v_cnt;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v_cnt + 1'b1;
        end
    end

    // Sync and blanking decode the next position so they register in step with x/y.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            video_on_q   <= 1'b1;
            hsync_q      <= ~SYNC_ACTIVE;
            vsync_q      <= ~SYNC_ACTIVE;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= p_tick && h_wrap && v_wrap;
            if (p_tick) begin
                h_cnt      <= h_next;
                v_cnt      <= v_next;
                video_on_q <= in_window(h_next, 0, H_DISPLAY - 1) &&
                              in_window(v_next, 0, V_DISPLAY - 1);
                hsync_q    <= in_window(h_next, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vsync_q    <= in_window(v_next, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            end
        end
    end

    assign vga.p_tick     = p_tick;
    assign vga.x          = h_cnt;
    assign vga.y          = v_cnt;
    assign vga.video_on   = video_on_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a default-timing instance and a reduced
// 14x7, CLK_DIV=2 instance share one monitor selected by sel.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       video_on;
        logic       hsync;
        logic       vsync;
        logic       frame_tick;
    } obs_t;

    logic clk = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    bit   sel = 1'b0;
    bit   armed = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    obs_t sb[$];

    always #5 clk = ~clk;

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();

    vga_sync_gen dut_a (
        .clk   (clk),
        .reset (reset_a),
        .vga   (if_a)
    );

    vga_sync_gen #(
        .CLK_DIV   (2),
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
        .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .vga   (if_b)
    );

    obs_t act;
    logic act_tick;
    assign act = sel ? {if_b.x, if_b.y, if_b.video_on, if_b.hsync, if_b.vsync, if_b.frame_tick}
                     : {if_a.x, if_a.y, if_a.video_on, if_a.hsync, if_a.vsync, if_a.frame_tick};
    assign act_tick = sel ? if_b.p_tick : if_a.p_tick;

    task automatic check(string name, int unsigned got, int unsigned want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // Hand-written timing windows for each configuration.
    function automatic obs_t expect_at(bit cfg, int x, int y, bit ft);
        obs_t e;
        e.x = 10'(x);
        e.y = 10'(y);
        if (!cfg) begin
            e.video_on = (x < 640) && (y < 480);
            e.hsync    = !(x >= 656 && x <= 751);
            e.vsync    = !(y >= 490 && y <= 491);
        end else begin
            e.video_on = (x < 8) && (y < 4);
            e.hsync    = !(x >= 10 && x <= 11);
            e.vsync    = !(y == 5);
        end
        e.frame_tick = ft;
        return e;
    endfunction

    // Monitor: pops one expectation on the cycle after each p_tick edge and
    // checks that outputs hold, with frame_tick low, on every other cycle.
    bit          armed_d = 1'b0;
    bit          upd = 1'b0;
    bit          seen_frame = 1'b0;
    int unsigned since = 0;
    int unsigned frame_gap = 0;
    obs_t        last;
    obs_t        exp_v;

    always @(negedge clk) begin
        if (armed) begin
            if (!armed_d) begin
                since      = 0;
                upd        = 1'b0;
                seen_frame = 1'b0;
                frame_gap  = 0;
                last       = expect_at(sel, 0, 0, 1'b0);
            end
            frame_gap++;
            if (upd) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_update: got %h expected no update", act);
                end else begin
                    exp_v = sb.pop_front();
                    check("pixel", act, exp_v);
                    last            = exp_v;
                    last.frame_tick = 1'b0;
                end
            end else begin
                check("hold", act, last);
            end
            if (act.frame_tick) begin
                if (seen_frame) check("frame_len", frame_gap, sel ? 196 : 1680000);
                seen_frame = 1'b1;
                frame_gap  = 0;
            end
            if (act_tick) begin
                check("tick_gap", since, sel ? 1 : 3);
                since = 0;
            end else begin
                since++;
            end
            upd = act_tick;
        end
        armed_d = armed;
    end

    task automatic do_reset(bit which, int cycles);
        armed = 1'b0;
        sb.delete();
        sel = which;
        if (which) reset_b = 1'b1; else reset_a = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        if (which) reset_b = 1'b0; else reset_a = 1'b0;
        armed = 1'b1;
    endtask

    // Pushes expectations for pixel steps n_from..n_to counted from (0,0).
    task automatic push_steps(bit cfg, int n_from, int n_to);
        int ht, vt, x, y;
        ht = cfg ? 14 : 800;
        vt = cfg ? 7 : 525;
        for (int n = n_from; n <= n_to; n++) begin
            x = n % ht;
            y = (n / ht) % vt;
            sb.push_back(expect_at(cfg, x, y, (x == 0) && (y == 0)));
        end
    endtask

    task automatic drain(string name, int budget);
        int left;
        left = budget;
        do begin
            @(posedge clk);
            left--;
        end while (sb.size() != 0 && left > 0);
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0 pending", name, sb.size());
            sb.delete();
        end
        #1;
    endtask

    initial begin
        // Default timing: reset release, one full line and into the next.
        do_reset(1'b0, 3);
        push_steps(1'b0, 1, 805);
        drain("line", 4000);

        // Run to (700,1), inside hsync, then a 1-clk reset mid-line.
        push_steps(1'b0, 806, 1500);
        drain("to_700", 4000);
        do_reset(1'b0, 1);
        push_steps(1'b0, 1, 3);
        drain("after_reset_a", 100);

        // Reduced timing: two full frames and a few pixels more.
        do_reset(1'b1, 2);
        push_steps(1'b1, 1, 199);
        drain("frames", 1000);

        // Stop at (13,6) so the reset lands on the wrap edge.
        push_steps(1'b1, 200, 293);
        drain("to_wrap", 1000);
        do_reset(1'b1, 1);
        push_steps(1'b1, 1, 3);
        drain("after_reset_b", 100);

        armed = 1'b0;
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
